// File: rtl/gray_count_sync_rx.sv
// gray_count_sync_rx: per-channel gray synchronisers, binary decode, step/dir
// strobes and sticky jump errors. Option: GRAY_COUNT_SYNC_RX_ERR_CNT_EN.
module gray_count_sync_rx #(
  parameter int WIDTH       = 4,
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS*WIDTH-1:0] in_gray,
  output logic [CHANNELS*WIDTH-1:0] out_count,
  output logic [CHANNELS-1:0]       out_step,
  output logic [CHANNELS-1:0]       out_dir,
  output logic [CHANNELS-1:0]       out_err,
  input  logic [CHANNELS-1:0]       err_clr,
`ifdef GRAY_COUNT_SYNC_RX_ERR_CNT_EN
  output logic [CHANNELS*8-1:0]     out_err_cnt,
`endif
  output logic                      out_settled
);

  localparam logic [2:0] SETTLE_V = 3'(SYNC_STAGES + 1);

  logic [2:0] settle_cnt;

  function automatic logic [WIDTH-1:0] g2b(
    input logic [WIDTH-1:0] g
  );
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Steps and errors are ignored until the chains hold real samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      settle_cnt  <= '0;
      out_settled <= 1'b0;
    end else begin
      if (settle_cnt != SETTLE_V) begin
        settle_cnt <= settle_cnt + 3'd1;
      end
      out_settled <= (settle_cnt == SETTLE_V);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    (* preserve, useioff = 0 *)
    logic [WIDTH-1:0] stg [SYNC_STAGES];

    logic [WIDTH-1:0] new_bin;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] delta;
    logic             is_up;
    logic             is_dn;
    logic             is_step;
    logic             jump_ev;
    logic             step_q;
    logic             dir_q;
    logic             err_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int k = 0; k < SYNC_STAGES; k++) begin
          stg[k] <= '0;
        end
      end else begin
        stg[0] <= in_gray[c*WIDTH +: WIDTH];
        for (int k = 1; k < SYNC_STAGES; k++) begin
          stg[k] <= stg[k-1];
        end
      end
    end

    // Modular delta: wrap in either direction is a legal single step.
    always_comb begin
      new_bin = g2b(stg[SYNC_STAGES-1]);
      delta   = new_bin - cnt_q;
      is_up   = (delta == WIDTH'(1));
      is_dn   = (delta == '1);
      is_step = out_settled & (is_up | is_dn);
      jump_ev = out_settled & (delta != '0) & ~is_up & ~is_dn;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q  <= '0;
        step_q <= 1'b0;
        dir_q  <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        cnt_q  <= new_bin;
        step_q <= is_step;
        if (is_step) begin
          dir_q <= is_up;
        end
        if (jump_ev) begin
          err_q <= 1'b1;
        end else if (err_clr[c]) begin
          err_q <= 1'b0;
        end
      end
    end

    assign out_count[c*WIDTH +: WIDTH] = cnt_q;
    assign out_step[c] = step_q;
    assign out_dir[c]  = dir_q;
    assign out_err[c]  = err_q;

`ifdef GRAY_COUNT_SYNC_RX_ERR_CNT_EN
    logic [7:0] ecnt_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        ecnt_q <= '0;
      end else if (err_clr[c]) begin
        ecnt_q <= {7'd0, jump_ev};
      end else if (jump_ev && ecnt_q != 8'hFF) begin
        ecnt_q <= ecnt_q + 8'd1;
      end
    end

    assign out_err_cnt[c*8 +: 8] = ecnt_q;
`endif
  end

endmodule

// File: tb/tb_gray_count_sync_rx.sv
// tb_gray_count_sync_rx: vector table, corner sequences and random traffic
// checked against a queue-based reference model.
module tb_gray_count_sync_rx;

  localparam int W  = 4;
  localparam int CH = 2;
  localparam int S  = 2;
  localparam int CW = W * CH;
  localparam int M  = (1 << W) - 1;

  logic          clk;
  logic          resetn;
  logic [CW-1:0] in_gray;
  logic [CW-1:0] out_count;
  logic [CH-1:0] out_step;
  logic [CH-1:0] out_dir;
  logic [CH-1:0] out_err;
  logic [CH-1:0] err_clr;
  logic          out_settled;
`ifdef GRAY_COUNT_SYNC_RX_ERR_CNT_EN
  logic [CH*8-1:0] out_err_cnt;
`endif

  gray_count_sync_rx #(
    .WIDTH(W),
    .CHANNELS(CH),
    .SYNC_STAGES(S)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .in_gray(in_gray),
    .out_count(out_count),
    .out_step(out_step),
    .out_dir(out_dir),
    .out_err(out_err),
    .err_clr(err_clr),
`ifdef GRAY_COUNT_SYNC_RX_ERR_CNT_EN
    .out_err_cnt(out_err_cnt),
`endif
    .out_settled(out_settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int         b0;
    int         b1;
    logic [1:0] step;
    logic [1:0] dir;
  } vec_t;

  vec_t vq[$];

  logic [CW-1:0] pipe_q[$];
  int            edges;
  logic [CW-1:0] m_count;
  logic [CH-1:0] m_step;
  logic [CH-1:0] m_dir;
  logic [CH-1:0] m_err;
  logic          m_set;
  int            m_ecnt[CH];
  int            cur[CH];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
               $time);
    else
      passed++;
  endtask

  function automatic int g2b(input int g);
    int b = 0;
    for (int i = 0; i < W; i++) b = b ^ (g >> i);
    return b & M;
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & M;
  endfunction

  task automatic set_ch(input int c, input int b);
    cur[c] = b & M;
    in_gray[c*W +: W] = W'(b2g(b));
  endtask

  task automatic model_reset();
    pipe_q.delete();
    for (int s = 0; s < S; s++) pipe_q.push_back('0);
    m_count = '0;
    m_step  = '0;
    m_dir   = '0;
    m_err   = '0;
    m_set   = 1'b0;
    edges   = 0;
    for (int c = 0; c < CH; c++) m_ecnt[c] = 0;
  endtask

  task automatic model_edge();
    logic [CW-1:0] g;
    int            nb;
    int            ob;
    int            d;
    logic          live;
    logic          ev;
    if (!resetn) begin
      model_reset();
      return;
    end
    g = pipe_q.pop_front();
    pipe_q.push_back(in_gray);
    live = (edges >= S + 2);
    for (int c = 0; c < CH; c++) begin
      nb = g2b(int'(g[c*W +: W]));
      ob = int'(m_count[c*W +: W]);
      d  = (nb - ob + M + 1) % (M + 1);
      m_step[c] = 1'b0;
      ev = 1'b0;
      if (live && d == 1) begin
        m_step[c] = 1'b1;
        m_dir[c]  = 1'b1;
      end else if (live && d == M) begin
        m_step[c] = 1'b1;
        m_dir[c]  = 1'b0;
      end else if (live && d != 0) begin
        ev = 1'b1;
      end
      if (ev) m_err[c] = 1'b1;
      else if (err_clr[c]) m_err[c] = 1'b0;
      if (err_clr[c]) m_ecnt[c] = ev ? 1 : 0;
      else if (ev && m_ecnt[c] < 255) m_ecnt[c]++;
      m_count[c*W +: W] = W'(nb);
    end
    edges++;
    m_set = (edges >= S + 2);
  endtask

  task automatic compare_all();
    check("count", 64'(out_count), 64'(m_count));
    check("step", 64'(out_step), 64'(m_step));
    check("dir", 64'(out_dir), 64'(m_dir));
    check("err", 64'(out_err), 64'(m_err));
    check("settled", 64'(out_settled), 64'(m_set));
`ifdef GRAY_COUNT_SYNC_RX_ERR_CNT_EN
    for (int c = 0; c < CH; c++)
      check("err_cnt", 64'(out_err_cnt[c*8 +: 8]), 64'(m_ecnt[c]));
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic add(input int b0, input int b1, input logic [1:0] st,
                     input logic [1:0] dr);
    vec_t v;
    v.b0 = b0;
    v.b1 = b1;
    v.step = st;
    v.dir = dr;
    vq.push_back(v);
  endtask

  initial begin
    for (int i = 1; i <= 16; i++) add(i % 16, 0, 2'b01, 2'b01);
    add(1, 1, 2'b11, 2'b11);
    add(2, 2, 2'b11, 2'b11);
    add(3, 1, 2'b11, 2'b01);
    add(4, 0, 2'b11, 2'b01);
    add(5, 15, 2'b11, 2'b01);

    resetn  = 1'b0;
    in_gray = '0;
    err_clr = '0;
    cur[0]  = 0;
    cur[1]  = 0;
    model_reset();
    tick(2);
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_settled", 64'(out_settled), 64'd0);

    resetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check("settle_edge", 64'(out_settled), 64'(k >= 4));
      check("idle_step", 64'(out_step), 64'd0);
    end

    foreach (vq[i]) begin
      set_ch(0, vq[i].b0);
      set_ch(1, vq[i].b1);
      tick(3);
      check("vec_count", 64'(out_count),
            64'({4'(vq[i].b1), 4'(vq[i].b0)}));
      check("vec_step", 64'(out_step), 64'(vq[i].step));
      check("vec_dir", 64'(out_dir), 64'(vq[i].dir));
      check("vec_err", 64'(out_err), 64'd0);
    end

    set_ch(0, 9);
    tick(3);
    check("jump_count", 64'(out_count[3:0]), 64'd9);
    check("jump_step", 64'(out_step), 64'd0);
    check("jump_err", 64'(out_err), 64'b01);
    tick(2);
    check("err_sticky", 64'(out_err), 64'b01);

    set_ch(0, 3);
    tick(2);
    err_clr = 2'b01;
    tick(1);
    check("clr_vs_set", 64'(out_err), 64'b01);
    check("clr_count", 64'(out_count[3:0]), 64'd3);
    tick(1);
    check("clr_alone", 64'(out_err), 64'b00);
    err_clr = '0;

    set_ch(0, 7);
    tick(3);
    check("pre_rst_count", 64'(out_count[3:0]), 64'd7);
    check("pre_rst_err", 64'(out_err), 64'b01);
    resetn = 1'b0;
    model_reset();
    #1;
    check("async_count", 64'(out_count), 64'd0);
    check("async_flags", 64'({out_step, out_dir, out_err}), 64'd0);
    check("async_settled", 64'(out_settled), 64'd0);
    set_ch(0, 6);
    set_ch(1, 2);
    @(negedge clk);
    tick(2);
    resetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check("post_settle", 64'(out_settled), 64'(k >= 4));
      check("post_step", 64'(out_step), 64'd0);
      check("post_err", 64'(out_err), 64'd0);
      if (k == 3) check("post_count", 64'(out_count), 64'h26);
    end

    for (int it = 0; it < 400; it++) begin
      for (int c = 0; c < CH; c++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 3) set_ch(c, cur[c] + 1);
        else if (r <= 5) set_ch(c, cur[c] + M);
        else if (r == 6) set_ch(c, int'($urandom_range(0, M)));
        err_clr[c] = ($urandom_range(0, 3) == 0);
      end
      tick(int'($urandom_range(1, 3)));
    end
    err_clr = '0;
    tick(4);
    err_clr = 2'b11;
    tick(1);
    err_clr = '0;
    check("final_err_clr", 64'(out_err), 64'd0);

`ifdef GRAY_COUNT_SYNC_RX_ERR_CNT_EN
    for (int i = 0; i < 300; i++) begin
      set_ch(0, (i % 2 == 1) ? 8 : 0);
      tick(1);
    end
    tick(4);
    check("ecnt_sat0", 64'(out_err_cnt[7:0]), 64'd255);
    check("ecnt_ch1", 64'(out_err_cnt[15:8]), 64'd0);
    err_clr = 2'b01;
    tick(1);
    err_clr = '0;
    check("ecnt_clr0", 64'(out_err_cnt[7:0]), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gray_count_sync_rx.md
Name: gray_count_sync_rx

Overview:
- Single-clock receive side of a multi-channel gray-coded counter crossing, for FIFO pointers or event counters arriving from foreign clock domains.
- Each channel's gray input passes through a parametrised synchroniser chain, is converted to binary and registered.
- Each channel also produces a step strobe with direction, plus a sticky error flag when the decoded value moves by more than one.
- Used by async FIFO address generators and by status blocks that need several foreign counters in the local domain.

Parameters:
- WIDTH, 4: bit-width of each counter, legal range 1..32.
- CHANNELS, 2: number of independent counters, legal range 1..16.
- SYNC_STAGES, 2: synchroniser flop depth, legal range 2..4.

Ports:
- clk  in  1  local clock.
- resetn  in  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion must be synchronised to clk externally.
- in_gray  in  CHANNELS*WIDTH  gray-coded counters from source domains. Channel c occupies bits [c*WIDTH +: WIDTH]. Asynchronous to clk.
- out_count  out  CHANNELS*WIDTH  decoded binary counters, same packing as in_gray.
- out_step  out  CHANNELS  one-cycle pulse when out_count[c] changes by exactly one.
- out_dir  out  CHANNELS  direction of the last step: 1 = up, 0 = down. Valid with out_step, held between steps.
- out_err  out  CHANNELS  sticky flag: illegal jump detected.
- err_clr  in  CHANNELS  synchronous per-channel clear of out_err.
- out_settled  out  1  high once the synchroniser chains have flushed after reset.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): all sync stages, out_count, out_step, out_dir, out_err, the settle counter and out_settled go to 0 immediately.
- Pipeline per channel: stage[0] <= in_gray, stage[k] <= stage[k-1], binary register <= g2b(stage[SYNC_STAGES-1]).
- Latency: a stable in_gray value appears on out_count SYNC_STAGES+1 clk edges later.
- Stage registers carry synthesis attributes preserve and useioff=0; no logic is placed between stages.
- Settle counter:
  - Counts from 0 to SYNC_STAGES+1 after reset, then holds.
  - out_settled = 1 when the count reaches SYNC_STAGES+1, i.e. on edge SYNC_STAGES+2 after reset release.
  - While out_settled = 0, out_step and error detection are masked; out_count still updates.
- Delta per channel: d = new_bin - out_count, computed modulo 2^WIDTH, registered on the same edge as out_count.
  - d = 0: no step.
  - d = 1: out_step = 1, out_dir = 1.
  - d = 2^WIDTH - 1: out_step = 1, out_dir = 0.
  - Any other d: out_step = 0, error event.
  - WIDTH = 1: every change is treated as a step with out_dir = 1; errors are impossible.
- Wrap-around: all-ones to 0 is an up step; 0 to all-ones is a down step. Neither is an error.
- Error event: out_err[c] <= 1 on the next edge. out_count still takes the new value, so there is no stall and no hold.
- err_clr[c] = 1: out_err[c] <= 0 on the next edge. If err_clr and an error event occur in the same cycle, set wins and out_err stays 1.
- out_step is a single-cycle pulse; out_step is 0 in every cycle in which out_count is unchanged.
- Channels are fully independent; there is no cross-channel coherence guarantee.

Optional Feature:
- Macro: GRAY_COUNT_SYNC_RX_ERR_CNT_EN.
- When defined:
  - Adds output out_err_cnt, CHANNELS*8 bits: a per-channel saturating count of error events, 0..255, holding at 255.
  - err_clr[c] also zeroes out_err_cnt[c].
  - Simultaneous clear and error sets the count to 1.
  - Reset value is 0.
- When undefined: the port and its counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, defaults, in_gray = 0 -> out_count = 0, out_settled rises on edge 4 after release, no out_step, no out_err.
- Channel 0 binary 0..15..0 (gray 0,1,3,2,...,8,0), one change per 3 clk -> out_count follows each value 3 edges after its change. Exactly 16 up steps; the 15->0 wrap is an up step (out_dir = 1); no out_err.
- Channel 1 counts down 2,1,0,15 while channel 0 counts up -> channel 1 gets 3 steps with out_dir = 0, channel 0 steps are unaffected, no errors.
- Channel 0 jumps binary 5 -> 9 (gray 0111 -> 1101) -> out_count = 9, out_step = 0, out_err[0] = 1 and stays 1. Then err_clr[0] in the same cycle as a second 9 -> 3 jump -> out_err[0] stays 1; err_clr alone clears it next edge.
- Assert resetn low mid-count with out_count = 7 and out_err = 1 -> all outputs 0 immediately. After release, a nonzero in_gray produces no step and no error before out_settled.
- With GRAY_COUNT_SYNC_RX_ERR_CNT_EN defined, 300 illegal jumps on channel 0 -> out_err_cnt[0] = 255; err_clr[0] -> 0; channel 1 count stays 0.
